pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measurement-side counterpart to the timer/PWM generator: samples an external PWM waveform and measures its period and high time in iCLK cycles.
- Results and status are exposed through the same 2-bit-address, 16-bit register interface the timer uses, with a read path added.
- Sits on the peripheral bus next to the PWM generator for loop-back checking or external-signal capture.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on iPWM; minimum 2.
- TMO_RST, 16'hFFFF: reset value of the timeout-limit register.

Ports:
- iCLK  in  1  clock; all logic on its rising edge.
- iRSTn  in  1  synchronous, active-low reset.
- iAddr  in  2  register address: 0 PERIOD (RO), 1 HIGH (RO), 2 TMO_LIMIT (RW), 3 STATUS (R/W1C).
- iWe  in  1  write strobe; the write takes effect on the iCLK edge where iWe=1.
- iWdata  in  16  write data.
- iStart  in  1  one-shot measurement start; level-sampled each cycle.
- iPWM  in  1  asynchronous PWM input.
- oRdata  out  16  combinational read mux of the register selected by iAddr.
- oValid  out  1  1-cycle pulse when a new measurement is latched.
- oBusy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (iRSTn=0 at a clock edge): PERIOD=0, HIGH=0, TMO_LIMIT=TMO_RST, STATUS=0, FSM=IDLE, synchronizer flops=0, oValid=0, oBusy=0. Reset has priority over everything, including mid-measurement.
- Input path: iPWM passes through SYNC_STAGES flops to give s_pwm, plus one flop for s_prev. rise = s_pwm & ~s_prev; fall = ~s_pwm & s_prev. Latency from an iPWM edge to rise/fall is SYNC_STAGES+1 cycles, identical for both edges, so measured widths are exact.
- STATUS bits: [0] busy (RO), [1] valid (sticky), [2] timeout (sticky), [3] overflow (sticky), [15:4] read as 0.
  - Writing addr 3 clears each of bits 1–3 where the corresponding iWdata bit is 1.
  - If a set event and a W1C clear hit the same bit in the same cycle, the set wins.
- Writes to addr 0 and addr 1 are ignored.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: on iStart go to ARM; clear cnt, hcnt and tcnt.
  - ARM: on rise set cnt=1 and go to HIGH. A level already high at start is ignored; only a true rising edge arms the measurement.
  - HIGH: cnt increments each cycle. On fall, hcnt=cnt, cnt=1, go to LOW.
  - LOW: cnt increments. On rise, PERIOD=hcnt+cnt, HIGH=hcnt, set valid, pulse oValid=1 for that cycle, go to IDLE.
  - Single-shot: a new iStart is required for each measurement.
- Reported values: PERIOD = cycles from rise to the next rise; HIGH = cycles from rise to fall. Example: 5 high, 11 low gives PERIOD=16, HIGH=5.
- iStart while busy: aborts the current measurement and restarts in ARM with counters cleared. PERIOD and HIGH hold their old values.
- Timeout: tcnt increments in ARM, HIGH and LOW, and clears on any rise or fall.
  - If TMO_LIMIT≠0 and tcnt reaches TMO_LIMIT, set timeout and go to IDLE. PERIOD and HIGH are unchanged.
  - TMO_LIMIT=0 disables the timeout.
  - A timeout and an edge in the same cycle: the edge wins.
- Overflow: cnt saturates at 16'hFFFF and sets overflow. The PERIOD sum (hcnt+cnt) also saturates at 16'hFFFF and sets overflow. The measurement still completes.
- TMO_LIMIT writes take effect the next cycle, including during a measurement.
- oBusy equals STATUS[0] and is registered from the FSM state.

Decomposition:
- Package pwm_capture_pkg holds:
  - the FSM state enum (IDLE/ARM/HIGH/LOW);
  - address constants ADDR_PERIOD=0, ADDR_HIGH=1, ADDR_TMO=2, ADDR_STAT=3;
  - STATUS bit indices;
  - the 16-bit data width constant.
- One sub-module, sync_edge_det: a parameterized SYNC_STAGES synchronizer plus edge detector, with outputs s_pwm, rise and fall. It is reused later for other external inputs.

Test Plan:
- Reset: pulse iRSTn low mid-measurement (HIGH state) → next cycle oBusy=0, STATUS=0, TMO_LIMIT reads 16'hFFFF, no oValid.
- Basic capture: iStart, then iPWM 5 high / 11 low, repeated → exactly one oValid pulse, PERIOD=16, HIGH=5, STATUS=16'h0002; a second iStart with 6 high / 5 low gives PERIOD=11, HIGH=6.
- Armed-high start: iPWM already high at iStart → the first partial pulse is ignored and the next full 3-high/7-low cycle gives PERIOD=10, HIGH=3.
- Restart and timeout: iStart again while in LOW → PERIOD/HIGH unchanged, FSM in ARM. Write TMO_LIMIT=20 and hold iPWM low → STATUS[2]=1 after 20 cycles in ARM, oBusy=0. Write STATUS 16'h0004 → STATUS[2]=0.
- W1C/set collision: write 16'h0002 to STATUS on the same cycle oValid pulses → STATUS[1] stays 1. Writes to addr 0 and 1 leave PERIOD and HIGH unchanged.
- Overflow: TMO_LIMIT=0, iPWM high for 70000 cycles then low 10, then high → HIGH=16'hFFFF, PERIOD=16'hFFFF, STATUS[3]=1, oValid pulses.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_capture_pkg;

  localparam int DATA_W = 16;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_TMO    = 2'd2;
  localparam logic [1:0] ADDR_STAT   = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_VALID = 1;
  localparam int STAT_TMO   = 2;
  localparam int STAT_OVF   = 3;

  // Saturating increment; MSB of the result flags an attempt to step past all-ones.
  function automatic logic [DATA_W:0] sat_inc(input data_t v);
    if (&v) return {1'b1, v};
    else    return {1'b0, v + 1'b1};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// SYNC_STAGES-deep synchronizer (two or more stages) plus rise/fall detector for an async input.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic din,
  output logic s_pwm,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_prev;

  // Shift the async input through the synchronizer, keep one cycle of history.
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], din};
      s_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign s_pwm = sync[SYNC_STAGES-1];
  assign rise  = s_pwm & ~s_prev;
  assign fall  = ~s_pwm & s_prev;

endmodule

// File: rtl/pwm_capture.sv
// Single-shot PWM period / high-time capture with a 4-register bus interface.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TMO_RST     = 16'hFFFF
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic [1:0]  iAddr,
  input  logic        iWe,
  input  logic [15:0] iWdata,
  input  logic        iStart,
  input  logic        iPWM,
  output logic [15:0] oRdata,
  output logic        oValid,
  output logic        oBusy
);

  state_t          state;
  data_t           cnt, hcnt, tcnt;
  data_t           period, high, tmo_limit;
  logic            st_valid, st_tmo, st_ovf;
  logic            busy, valid_q;
  logic            rise, fall, s_pwm_unused;
  logic [DATA_W:0] cnt_nx, tcnt_nx, sum;
  logic            tmo_hit, stat_we;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .gclk   (iCLK),
    .grst_n (iRSTn),
    .din    (iPWM),
    .s_pwm  (s_pwm_unused),
    .rise   (rise),
    .fall   (fall)
  );

  assign cnt_nx  = sat_inc(cnt);
  assign tcnt_nx = sat_inc(tcnt);
  assign sum     = {1'b0, hcnt} + {1'b0, cnt};
  // Fires on the cycle the timeout counter would reach the limit; zero disables it.
  assign tmo_hit = (tmo_limit != '0) && (tcnt_nx[DATA_W-1:0] >= tmo_limit);
  assign stat_we = iWe && (iAddr == ADDR_STAT);

  assign oValid = valid_q;
  assign oBusy  = busy;

  // Timeout-limit register; PERIOD/HIGH are read-only so only this address stores data.
  always_ff @(posedge iCLK) begin
    if (!iRSTn)                         tmo_limit <= TMO_RST;
    else if (iWe && iAddr == ADDR_TMO)  tmo_limit <= iWdata;
  end

  // Measurement FSM with sticky status; W1C clears come first so a same-cycle set wins.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      tcnt     <= '0;
      period   <= '0;
      high     <= '0;
      st_valid <= 1'b0;
      st_tmo   <= 1'b0;
      st_ovf   <= 1'b0;
      busy     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (stat_we) begin
        if (iWdata[STAT_VALID]) st_valid <= 1'b0;
        if (iWdata[STAT_TMO])   st_tmo   <= 1'b0;
        if (iWdata[STAT_OVF])   st_ovf   <= 1'b0;
      end
      if (iStart) begin
        // Start from idle or abort-and-rearm; previous results are kept.
        state <= S_ARM;
        busy  <= 1'b1;
        cnt   <= '0;
        hcnt  <= '0;
        tcnt  <= '0;
      end else begin
        case (state)
          S_ARM: begin
            if (rise) begin
              cnt   <= data_t'(1);
              tcnt  <= '0;
              state <= S_HIGH;
            end else if (fall) begin
              tcnt <= '0;
            end else if (tmo_hit) begin
              st_tmo <= 1'b1;
              state  <= S_IDLE;
              busy   <= 1'b0;
            end else begin
              tcnt <= tcnt_nx[DATA_W-1:0];
            end
          end
          S_HIGH: begin
            if (fall) begin
              hcnt  <= cnt;
              cnt   <= data_t'(1);
              tcnt  <= '0;
              state <= S_LOW;
            end else if (tmo_hit) begin
              st_tmo <= 1'b1;
              state  <= S_IDLE;
              busy   <= 1'b0;
            end else begin
              cnt  <= cnt_nx[DATA_W-1:0];
              tcnt <= tcnt_nx[DATA_W-1:0];
              if (cnt_nx[DATA_W]) st_ovf <= 1'b1;
            end
          end
          S_LOW: begin
            if (rise) begin
              period   <= sum[DATA_W] ? '1 : sum[DATA_W-1:0];
              high     <= hcnt;
              st_valid <= 1'b1;
              valid_q  <= 1'b1;
              if (sum[DATA_W]) st_ovf <= 1'b1;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else if (tmo_hit) begin
              st_tmo <= 1'b1;
              state  <= S_IDLE;
              busy   <= 1'b0;
            end else begin
              cnt  <= cnt_nx[DATA_W-1:0];
              tcnt <= tcnt_nx[DATA_W-1:0];
              if (cnt_nx[DATA_W]) st_ovf <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Combinational register read mux.
  always_comb begin
    oRdata = '0;
    case (iAddr)
      ADDR_PERIOD: oRdata = period;
      ADDR_HIGH:   oRdata = high;
      ADDR_TMO:    oRdata = tmo_limit;
      default: begin
        oRdata[STAT_BUSY]  = busy;
        oRdata[STAT_VALID] = st_valid;
        oRdata[STAT_TMO]   = st_tmo;
        oRdata[STAT_OVF]   = st_ovf;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected results, a monitor checks on oValid.
module tb_pwm_capture;

  logic        iCLK, iRSTn, iWe, iStart, iPWM;
  logic [1:0]  stim_addr, mon_addr, iAddr;
  logic        mon_sel;
  logic [15:0] iWdata, oRdata;
  logic        oValid, oBusy;

  assign iAddr = mon_sel ? mon_addr : stim_addr;

  pwm_capture dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iAddr(iAddr), .iWe(iWe), .iWdata(iWdata),
    .iStart(iStart), .iPWM(iPWM), .oRdata(oRdata), .oValid(oValid), .oBusy(oBusy)
  );

  typedef struct { logic [15:0] period; logic [15:0] high; } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0, nvalid = 0, npushed = 0;
  logic [15:0] last_p = 16'd0, last_h = 16'd0;

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pwm(input logic lvl, input int n);
    iPWM = lvl;
    repeat (n) tick();
  endtask

  task automatic start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    stim_addr = a; iWdata = d; iWe = 1'b1;
    tick();
    iWe = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    stim_addr = a;
    #1 v = oRdata;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wait_done: %0d results still pending after %0d cycles, required 0", sb.size(), bound);
      sb.delete();
    end
  endtask

  task automatic push(input int h, input int l);
    exp_t e;
    e.period = (h + l > 65535) ? 16'hFFFF : 16'(h + l);
    e.high   = (h > 65535) ? 16'hFFFF : 16'(h);
    sb.push_back(e);
    npushed++;
    last_p = e.period;
    last_h = e.high;
  endtask

  // One full measurement: h high / l low repeated, only the first period counts.
  task automatic measure(input int h, input int l, input int reps);
    pwm(1'b0, 6);
    push(h, l);
    start();
    for (int r = 0; r < reps; r++) begin
      pwm(1'b1, h);
      pwm(1'b0, l);
    end
    pwm(1'b1, 3);
    pwm(1'b0, 2);
    wait_done(20);
  endtask

  // Monitor: on every oValid read PERIOD/HIGH and compare with the oldest expectation.
  initial begin
    logic [15:0] p, h;
    exp_t e;
    mon_sel = 1'b0;
    mon_addr = 2'd0;
    forever begin
      @(negedge iCLK);
      if (oValid === 1'b1) begin
        nvalid++;
        mon_sel = 1'b1;
        mon_addr = 2'd0;
        #1 p = oRdata;
        mon_addr = 2'd1;
        #1 h = oRdata;
        mon_sel = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pulse with period=%0d high=%0d, required none", p, h);
        end else begin
          e = sb.pop_front();
          chk("period", p, e.period);
          chk("high", h, e.high);
        end
      end
    end
  end

  initial begin
    logic [15:0] v;
    bit seen;
    iRSTn = 1'b0; iWe = 1'b0; iStart = 1'b0; iPWM = 1'b0;
    iWdata = 16'd0; stim_addr = 2'd0;
    repeat (3) tick();
    iRSTn = 1'b1;

    // Reset state
    rd(2'd0, v); chk("rst_period", v, 0);
    rd(2'd1, v); chk("rst_high", v, 0);
    rd(2'd2, v); chk("rst_tmo", v, 16'hFFFF);
    rd(2'd3, v); chk("rst_status", v, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_valid", oValid, 0);

    // Basic capture, repeated waveform gives a single result
    measure(5, 11, 3);
    rd(2'd3, v); chk("basic_status", v, 16'h0002);
    chk("basic_busy", oBusy, 0);
    measure(6, 5, 1);

    // Already-high input at start: partial pulse ignored
    pwm(1'b1, 6);
    push(3, 7);
    start();
    pwm(1'b1, 2); pwm(1'b0, 4);
    pwm(1'b1, 3); pwm(1'b0, 7);
    pwm(1'b1, 3); pwm(1'b0, 2);
    wait_done(20);

    // Randomized widths
    for (int i = 0; i < 8; i++) begin
      int h, l;
      h = int'($urandom_range(1, 40));
      l = int'($urandom_range(1, 40));
      measure(h, l, 1);
    end

    // Restart while in LOW, then timeout in ARM
    pwm(1'b0, 6);
    start();
    pwm(1'b1, 5); pwm(1'b0, 4);
    start();
    wr(2'd2, 16'd20);
    chk("restart_busy", oBusy, 1);
    rd(2'd0, v); chk("restart_period", v, last_p);
    rd(2'd1, v); chk("restart_high", v, last_h);
    repeat (18) tick();
    rd(2'd3, v); chk("tmo_before", v[2:0], 3'b011);
    tick();
    rd(2'd3, v); chk("tmo_status", v, 16'h0006);
    chk("tmo_busy", oBusy, 0);
    wr(2'd3, 16'h0004);
    rd(2'd3, v); chk("tmo_clear", v, 16'h0002);

    // W1C of valid colliding with the set: set wins
    wr(2'd3, 16'h0002);
    rd(2'd3, v); chk("valid_clear", v, 0);
    pwm(1'b0, 6);
    push(4, 6);
    start();
    pwm(1'b1, 4); pwm(1'b0, 6);
    iPWM = 1'b1;
    stim_addr = 2'd3; iWdata = 16'h0002; iWe = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (oValid === 1'b1) seen = 1'b1;
    end
    iWe = 1'b0;
    chk("collide_seen", seen, 1);
    rd(2'd3, v); chk("collide_status", v, 16'h0002);
    pwm(1'b1, 2); pwm(1'b0, 2);
    wait_done(10);
    wr(2'd0, 16'h1234);
    wr(2'd1, 16'h5678);
    rd(2'd0, v); chk("ro_period", v, 16'd10);
    rd(2'd1, v); chk("ro_high", v, 16'd4);

    // Reset in the middle of a measurement
    wr(2'd2, 16'd50);
    pwm(1'b0, 6);
    start();
    pwm(1'b1, 8);
    iRSTn = 1'b0;
    tick();
    iRSTn = 1'b1;
    chk("mid_rst_busy", oBusy, 0);
    chk("mid_rst_valid", oValid, 0);
    rd(2'd3, v); chk("mid_rst_status", v, 0);
    rd(2'd2, v); chk("mid_rst_tmo", v, 16'hFFFF);
    rd(2'd0, v); chk("mid_rst_period", v, 0);
    pwm(1'b1, 2); pwm(1'b0, 6);

    // Overflow with timeout disabled
    wr(2'd2, 16'd0);
    measure(70000, 10, 1);
    rd(2'd3, v); chk("ovf_status", v, 16'h000A);

    chk("valid_count", nvalid, npushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
